// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// spi_pkg : shared frame constants and state encoding for spi_slave_regfile
// Revision: 1.0
// ============================================================================
package spi_pkg;

  localparam int CMD_RW_BIT = 7;
  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] CMD_LAST_CNT   = CNT_W'(FRAME_BITS / 2 - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST_CNT = CNT_W'(FRAME_BITS - 1);

  localparam logic [2:0] STATUS_ADDR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
// spi_edge_sync : synchronizes sclk/cs/mosi and derives mode-aware edge strobes
// Revision: 1.0
// ============================================================================
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cpol,
  input  logic cpha,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic sample_edge,
  output logic shift_edge,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  // Bit order in each stage: {sclk, cs, mosi}
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] sync_d [SYNC_STAGES];
  logic [1:0] prev_q;
  logic [1:0] prev_d;
  logic [2:0] sync_rst;
  logic       sclk_s;
  logic       cs_s;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       lead_edge;
  logic       trail_edge;

  // Reset to the bus idle levels so no spurious edge follows reset release.
  assign sync_rst = {cpol, 1'b1, 1'b0};

  always_comb begin
    sync_d[0] = {sclk, cs, mosi};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign {sclk_s, cs_s, mosi_s} = sync_q[SYNC_STAGES-1];
  assign prev_d = {sclk_s, cs_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_rst;
      end
      prev_q <= sync_rst[2:1];
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= prev_d;
    end
  end

  assign sclk_rise   = sclk_s & ~prev_q[1];
  assign sclk_fall   = ~sclk_s & prev_q[1];
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_s & prev_q[0];
  assign cs_rise     = cs_s & ~prev_q[0];

endmodule
`default_nettype wire

// File: rtl/spi_slave_regfile.sv
`default_nettype none
// ============================================================================
// spi_slave_regfile : 8 x 8-bit register file behind a 16-bit-frame SPI slave
// Revision: 1.0
// ============================================================================
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] reg0_out,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] RO_ADDR = ADDR_W'(STATUS_ADDR);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic              cmd_rw_q, cmd_rw_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              miso_q, miso_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              frame_err_q, frame_err_d;

  logic              sample_edge;
  logic              shift_edge;
  logic              cs_fall;
  logic              cs_rise;
  logic              mosi_s;
  logic [DATA_W-1:0] rx_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_val;
  logic              cmd_done;
  logic              frame_done;
  logic              abort;

  spi_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk         (clk),
    .rst         (rst),
    .cpol        (cpol),
    .cpha        (cpha),
    .sclk        (sclk),
    .cs          (cs),
    .mosi        (mosi),
    .sample_edge (sample_edge),
    .shift_edge  (shift_edge),
    .cs_fall     (cs_fall),
    .cs_rise     (cs_rise),
    .mosi_s      (mosi_s)
  );

  assign rx_next    = {rx_sr_q, mosi_s};
  assign rd_addr    = rx_next[ADDR_W-1:0];
  assign rd_val     = (rd_addr == RO_ADDR) ? frame_cnt_q : regs_q[rd_addr];
  assign cmd_done   = (state_q == CMD) && sample_edge && (bit_cnt_q == CMD_LAST_CNT);
  assign frame_done = (state_q == DATA) && sample_edge && (bit_cnt_q == FRAME_LAST_CNT);
  assign abort      = (state_q != IDLE) && cs_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall)    state_d = CMD;
      CMD:     if (cmd_done)   state_d = DATA;
      DATA:    if (frame_done) state_d = CMD;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    cmd_rw_d    = cmd_rw_q;
    cmd_addr_d  = cmd_addr_q;
    regs_d      = regs_q;
    frame_cnt_d = frame_cnt_q;
    miso_d      = miso_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;

    if (state_q == IDLE) begin
      miso_d = 1'b0;
    end

    if ((state_q != IDLE) && sample_edge) begin
      rx_sr_d   = rx_next[DATA_W-2:0];
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    if (cmd_done) begin
      cmd_rw_d   = rx_next[CMD_RW_BIT];
      cmd_addr_d = rd_addr;
      if (!rx_next[CMD_RW_BIT]) begin
        tx_sr_d = rd_val;
      end
    end

    if ((state_q == DATA) && shift_edge && !cmd_rw_q) begin
      miso_d  = tx_sr_q[DATA_W-1];
      tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
    end

    if (frame_done) begin
      bit_cnt_d   = '0;
      miso_d      = 1'b0;
      frame_cnt_d = frame_cnt_q + DATA_W'(1);
      if (cmd_rw_q && (cmd_addr_q != RO_ADDR)) begin
        regs_d[cmd_addr_q] = rx_next;
        wr_strobe_d        = 1'b1;
        wr_addr_d          = cmd_addr_q;
        wr_data_d          = rx_next;
      end
    end

    // A completing 16th sample wins over a simultaneous cs rise.
    if (abort) begin
      bit_cnt_d   = '0;
      miso_d      = 1'b0;
      frame_err_d = !frame_done && ((bit_cnt_q != '0) || sample_edge);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      cmd_rw_q    <= 1'b0;
      cmd_addr_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      frame_cnt_q <= '0;
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_addr_q  <= cmd_addr_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      frame_cnt_q <= frame_cnt_d;
      miso_q      <= miso_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso      = miso_q;
  assign reg0_out  = regs_q[0];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_regfile.sv
`default_nettype none
// ============================================================================
// tb_spi_slave_regfile : directed SPI-master bench for spi_slave_regfile
// Revision: 1.0
// ============================================================================
module tb_spi_slave_regfile;

  localparam int HALF = 50;

  logic       clk;
  logic       rst;
  logic       cpol;
  logic       cpha;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic [7:0] reg0_out;
  logic       wr_strobe;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;

  int         n_checks;
  int         n_fail;
  int         strobe_cnt;
  int         err_cnt;
  int         miso_hi;
  logic [2:0] last_addr;
  logic [7:0] last_data;

  spi_slave_regfile u_dut (
    .clk       (clk),
    .rst       (rst),
    .cpol      (cpol),
    .cpha      (cpha),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .reg0_out  (reg0_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      last_addr  <= wr_addr;
      last_data  <= wr_data;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (miso)      miso_hi <= miso_hi + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sclk = pol;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic cs_begin();
    sclk = cpol;
    cs   = 1'b0;
    #(HALF);
  endtask

  task automatic cs_end();
    #(HALF);
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Drives nedges sclk edges of a 16-bit frame, capturing miso on sample edges.
  task automatic spi_bits(input logic [15:0] tx, input int nedges, output logic [15:0] rx);
    int   b;
    logic lead;
    rx = '0;
    if (!cpha) mosi = tx[15];
    #(HALF);
    for (int e = 0; e < nedges; e++) begin
      b    = e / 2;
      lead = (e % 2 == 0);
      if (lead == !cpha) rx[15-b] = miso;
      sclk = lead ? ~cpol : cpol;
      if (cpha && lead) mosi = tx[15-b];
      if (!cpha && !lead && b < 15) mosi = tx[14-b];
      #(HALF);
    end
  endtask

  task automatic spi_write(input logic [7:0] cmd, input logic [7:0] data);
    logic [15:0] rx;
    cs_begin();
    spi_bits({cmd, data}, 32, rx);
    cs_end();
  endtask

  task automatic spi_read(input logic [7:0] cmd, output logic [15:0] rx);
    cs_begin();
    spi_bits({cmd, 8'h00}, 32, rx);
    cs_end();
  endtask

  initial begin
    #(1000000);
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] rx;
    int s0;
    int e0;
    int m0;

    rst  = 1'b1;
    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_miso",      32'(miso),      32'h0);
    check("rst_reg0",      32'(reg0_out),  32'h00);
    check("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);

    // Mode 00 write of reg2
    s0 = strobe_cnt;
    m0 = miso_hi;
    spi_write(8'h82, 8'hA5);
    check("w2_strobes",   strobe_cnt - s0, 1);
    check("w2_addr",      32'(last_addr), 32'h2);
    check("w2_data",      32'(last_data), 32'hA5);
    check("w2_miso_low",  miso_hi - m0, 0);
    spi_read(8'h02, rx);
    check("r2_data",      32'(rx[7:0]), 32'hA5);

    // Mode 00 write reg0 then read it back
    spi_write(8'h80, 8'h3C);
    check("w0_reg0_out",  32'(reg0_out), 32'h3C);
    spi_read(8'h00, rx);
    check("r0_data",      32'(rx[7:0]), 32'h3C);
    check("r0_cmd_miso",  32'(rx[15:8]), 32'h00);

    // Remaining modes
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0]);
      spi_write(8'h85, 8'h96);
      spi_read(8'h05, rx);
      check($sformatf("r5_mode%0d", m), 32'(rx[7:0]), 32'h96);
    end

    // Aborted write after 11 edges
    set_mode(1'b0, 1'b0);
    s0 = strobe_cnt;
    e0 = err_cnt;
    cs_begin();
    spi_bits({8'h81, 8'hFF}, 11, rx);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    sclk = cpol;
    repeat (10) @(negedge clk);
    check("abort_frame_err", err_cnt - e0, 1);
    check("abort_strobes",   strobe_cnt - s0, 0);
    spi_read(8'h01, rx);
    check("abort_reg1",      32'(rx[7:0]), 32'h00);
    spi_write(8'h81, 8'h11);
    spi_read(8'h01, rx);
    check("after_abort_reg1", 32'(rx[7:0]), 32'h11);
    check("after_abort_strobes", strobe_cnt - s0, 1);

    // Back-to-back frames after a fresh reset; frame counter on reg7
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    s0 = strobe_cnt;
    cs_begin();
    spi_bits({8'h83, 8'h44}, 32, rx);
    spi_bits({8'h84, 8'h22}, 32, rx);
    spi_bits({8'h07, 8'h00}, 32, rx);
    cs_end();
    check("b2b_reg7",    32'(rx[7:0]), 32'h02);
    check("b2b_strobes", strobe_cnt - s0, 2);
    check("b2b_addr",    32'(last_addr), 32'h4);
    check("b2b_data",    32'(last_data), 32'h22);
    s0 = strobe_cnt;
    spi_write(8'h87, 8'h55);
    check("w7_strobes",  strobe_cnt - s0, 0);
    spi_read(8'h07, rx);
    check("r7_count",    32'(rx[7:0]), 32'h04);

    // Reset in the middle of a read data byte
    spi_write(8'h80, 8'h3C);
    spi_write(8'h82, 8'hA5);
    cs_begin();
    spi_bits({8'h02, 8'h00}, 20, rx);
    repeat (4) @(negedge clk);
    check("mid_read_miso", 32'(miso), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_miso", 32'(miso),     32'h0);
    check("rst_mid_reg0", 32'(reg0_out), 32'h00);
    cs   = 1'b1;
    sclk = cpol;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    spi_read(8'h02, rx);
    check("post_rst_reg2", 32'(rx[7:0]), 32'h00);
    spi_read(8'h07, rx);
    check("post_rst_reg7", 32'(rx[7:0]), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- SPI slave register file. It sits directly downstream of the top_SPI master and consumes its sclk/cs/mosi; it drives the miso line back to the master.
- It holds 8 x 8-bit registers that the master reads and writes with 16-bit frames: a command byte followed by a data byte.
- All four CPOL/CPHA modes are supported. SPI inputs are oversampled on the system clock.
- reg0 is exported so the board 7-segment path can display it.

Parameters:
- DATA_W, 8, register and byte width.
- ADDR_W, 3, register address width (8 registers).
- SYNC_STAGES, 2, synchronizer depth on sclk/cs/mosi.

Ports:
- clk  in  1  system clock; frequency ≥ 8x sclk.
- rst  in  1  reset.
- cpol  in  1  clock polarity; static while cs is low.
- cpha  in  1  clock phase; static while cs is low.
- sclk  in  1  SPI clock from master.
- cs  in  1  active-low chip select.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- reg0_out  out  8  current value of register 0.
- wr_strobe  out  1  1-clk pulse on each committed write.
- wr_addr  out  3  address of the committed write.
- wr_data  out  8  data of the committed write.
- frame_err  out  1  1-clk pulse when cs rises mid-frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - all registers 0x00; reg0_out 0x00; miso 0.
  - wr_strobe 0, wr_addr 0, wr_data 0, frame_err 0.
  - bit counter 0, shift registers 0, state IDLE.
- Input sampling and edges:
  - sclk, cs and mosi each pass through SYNC_STAGES flops.
  - Edge detect uses the synchronized value versus its previous value.
  - Leading edge = rise if cpol=0, fall if cpol=1.
  - sample_edge = leading edge if cpha=0, trailing edge if cpha=1.
  - shift_edge is the opposite edge.
- Frame format:
  - MSB first.
  - Command byte: bit7 = RW (1 = write, 0 = read), bits[2:0] = address, bits[6:3] ignored.
  - Data byte follows the command byte.
- State machine:
  - IDLE -> CMD on synchronized cs falling.
  - CMD: shift mosi into rx_sr on each sample_edge. On the 8th sample, latch the command and move to DATA.
    - If read: load tx_sr with reg[addr] on the same clk.
  - DATA: on each sample_edge shift rx_sr. On each shift_edge shift tx_sr left.
  - End of data byte (16th sample): if write and addr != 7, commit rx byte to reg[addr]. One clk later pulse wr_strobe with wr_addr/wr_data.
  - After the 16th sample, return to CMD with counter 0; back-to-back frames inside one cs-low are allowed.
  - cs rise: go to IDLE from any state.
    - If the counter is nonzero, pulse frame_err and discard the partial frame; no register change.
- miso:
  - 0 in IDLE and during the command byte.
  - After the read load, the first shift_edge presents tx_sr[7]; each later shift_edge presents the next bit.
  - During a write's data byte, miso stays 0.
  - Update latency is ≤ SYNC_STAGES+1 clk after the sclk edge.
- Register 7 is read-only:
  - it reads as the count of completed frames mod 256, incremented at each frame's 16th sample;
  - writes to it are ignored with no wr_strobe.
- Simultaneous events: a cs rise coinciding with the 16th sample completes the frame first (commit/strobe occurs) and then goes to IDLE; no frame_err.
- Reset mid-frame: returns to the reset state within 1 clk. Registers clear.

Decomposition:
- Shared package spi_pkg holds:
  - localparams CMD_RW_BIT=7 and FRAME_BITS=16;
  - the state encoding IDLE/CMD/DATA;
  - the read-only address STATUS_ADDR=7.
- One sub-module, spi_edge_sync: synchronizer plus cpol/cpha-aware sample_edge/shift_edge/cs_fall/cs_rise generation.

Test Plan:
- Mode 00, clk 100 MHz, sclk 10 MHz. Frame write cmd 0x82, data 0xA5 -> reg2=0xA5; one wr_strobe with wr_addr=2, wr_data=0xA5; miso 0 throughout.
- Mode 00. Write 0x3C to addr 0, then read cmd 0x00 -> miso shifts 0x3C MSB first in the data byte; reg0_out=0x3C after the write.
- Modes 01, 10 and 11 each. Write 0x96 to addr 5, then read addr 5 -> mosi/miso bits match 0x96 in every mode.
- cs raised after 11 sclk edges of a write to addr 1 with data 0xFF -> frame_err pulses once; reg1 stays 0x00; no wr_strobe; the next full frame works.
- Three back-to-back frames in one cs-low, the last a read of addr 7 -> miso returns 0x02 (count before the third frame completes); a write of 0x55 to addr 7 -> no change, no strobe.
- rst asserted mid read data byte -> miso 0 and all registers 0x00 on the next clk; a subsequent read of addr 2 returns 0x00.
